// File: rtl/board_pos_streamer.sv
// Authoritative chess board holder: loads a serial position, applies one UCI move
// per request, and re-streams the 64 squares to the move generator on start.
`timescale 1ns/1ps
module board_pos_streamer #(
  parameter int SQUARES = 64,
  parameter int PIECE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_pos_valid,
  input  logic [PIECE_W-1:0] in_pos_data,
  input  logic               in_pos_sop,
  input  logic               in_pos_eop,
  input  logic               in_wtp,
  input  logic [3:0]         in_castle,
  input  logic [2:0]         in_ep,
  input  logic               in_ep_valid,
  input  logic               i_uci_valid,
  input  logic [19:0]        i_uci_data,
  output logic               i_uci_ready,
  input  logic               start,
  output logic               out_pos_valid,
  output logic [PIECE_W-1:0] out_pos_data,
  output logic               out_pos_sop,
  output logic               out_pos_eop,
  output logic               out_wtp,
  output logic [3:0]         out_castle,
  output logic [2:0]         out_ep,
  output logic               out_ep_valid,
  output logic               o_busy,
  output logic               o_err
);

  // state  | meaning
  // IDLE   | waiting; load sop beat > move > start
  // LOAD   | writing board beats in index order until eop
  // APPLY  | single-cycle make-move of the latched uci word
  // STREAM | 64 registered square beats, then one drain cycle

  localparam int IDX_W = $clog2(SQUARES);
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(SQUARES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_STREAM
  } state_t;

  state_t              state, state_nxt;
  logic [PIECE_W-1:0]  board [SQUARES];
  logic [IDX_W:0]      idx;
  logic [19:0]         mv;
  logic                wtp;
  logic [3:0]          castle;
  logic [2:0]          ep;
  logic                ep_valid;
  logic                load_sop;

  logic [1:0]          promote;
  logic [2:0]          from_r, from_f, to_r, to_f;
  logic [IDX_W-1:0]    from_sq, to_sq, ep_cap_sq, rook_src_sq, rook_dst_sq;
  logic [PIECE_W-1:0]  moved, placed;
  logic [2:0]          promo_code;
  logic                is_pawn, is_king, reject, promo, ep_cap;
  logic                castle_short, castle_long, dbl_push;
  logic [3:0]          castle_nxt;
  logic                unused_fields;

  assign load_sop      = in_pos_valid && in_pos_sop;
  assign promote       = mv[19:18];
  assign from_r        = mv[14:12];
  assign from_f        = mv[11:9];
  assign to_r          = mv[5:3];
  assign to_f          = mv[2:0];
  assign unused_fields = ^{mv[17:15], mv[8:6]};

  assign out_wtp      = wtp;
  assign out_castle   = castle;
  assign out_ep       = ep;
  assign out_ep_valid = ep_valid;

  // Move decode: the moving piece comes from the board, never from the uci word.
  always_comb begin
    from_sq     = {from_r, from_f};
    to_sq       = {to_r, to_f};
    ep_cap_sq   = {from_r, to_f};
    moved       = board[from_sq];
    is_pawn     = (moved[2:0] == 3'd6);
    is_king     = (moved[2:0] == 3'd1);
    reject      = (moved[2:0] == 3'd0) || (moved[3] != wtp);
    promo       = is_pawn && (moved[3] ? (to_r == 3'd7) : (to_r == 3'd0));
    case (promote)
      2'd0:    promo_code = 3'd2;
      2'd1:    promo_code = 3'd4;
      2'd2:    promo_code = 3'd3;
      default: promo_code = 3'd5;
    endcase
    placed       = promo ? {moved[3], promo_code} : moved;
    ep_cap       = is_pawn && (from_f != to_f) && (board[to_sq] == '0);
    castle_short = is_king && (from_f == 3'd4) && (to_f == 3'd6);
    castle_long  = is_king && (from_f == 3'd4) && (to_f == 3'd2);
    rook_src_sq  = castle_short ? {from_r, 3'd7} : {from_r, 3'd0};
    rook_dst_sq  = castle_short ? {from_r, 3'd5} : {from_r, 3'd3};
    dbl_push     = is_pawn && (({1'b0, to_r} == {1'b0, from_r} + 4'd2) ||
                               ({1'b0, from_r} == {1'b0, to_r} + 4'd2));
    castle_nxt = castle;
    if (is_king) begin
      if (moved[3]) castle_nxt[3:2] = 2'b00;
      else          castle_nxt[1:0] = 2'b00;
    end
    if (from_sq == 6'd7  || to_sq == 6'd7)  castle_nxt[3] = 1'b0;
    if (from_sq == 6'd0  || to_sq == 6'd0)  castle_nxt[2] = 1'b0;
    if (from_sq == 6'd63 || to_sq == 6'd63) castle_nxt[1] = 1'b0;
    if (from_sq == 6'd56 || to_sq == 6'd56) castle_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (load_sop)         state_nxt = in_pos_eop ? S_IDLE : S_LOAD;
        else if (i_uci_valid) state_nxt = S_APPLY;
        else if (start)       state_nxt = S_STREAM;
      end
      S_LOAD:   if (in_pos_valid && in_pos_eop) state_nxt = S_IDLE;
      S_APPLY:  state_nxt = S_IDLE;
      S_STREAM: if (idx[IDX_W]) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    i_uci_ready = (state == S_IDLE) && !load_sop;
    o_busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SQUARES; i++) board[i] <= '0;
      idx      <= '0;
      mv       <= '0;
      wtp      <= 1'b1;
      castle   <= '0;
      ep       <= '0;
      ep_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_sop) begin
            for (int i = 0; i < SQUARES; i++) board[i] <= '0;
            board[0] <= in_pos_data;
            idx      <= (IDX_W + 1)'(1);
            if (in_pos_eop) begin
              wtp      <= in_wtp;
              castle   <= in_castle;
              ep       <= in_ep;
              ep_valid <= in_ep_valid;
            end
          end else if (i_uci_valid) begin
            mv <= i_uci_data;
          end else if (start) begin
            idx <= '0;
          end
        end
        S_LOAD: begin
          if (in_pos_valid) begin
            if (in_pos_sop) begin
              for (int i = 0; i < SQUARES; i++) board[i] <= '0;
              board[0] <= in_pos_data;
              idx      <= (IDX_W + 1)'(1);
            end else if (!idx[IDX_W]) begin
              board[idx[IDX_W-1:0]] <= in_pos_data;
              idx                   <= idx + 1'b1;
            end
            if (in_pos_eop) begin
              wtp      <= in_wtp;
              castle   <= in_castle;
              ep       <= in_ep;
              ep_valid <= in_ep_valid;
            end
          end
        end
        S_APPLY: begin
          if (!reject) begin
            board[from_sq] <= '0;
            board[to_sq]   <= placed;
            if (ep_cap) board[ep_cap_sq] <= '0;
            if (castle_short || castle_long) begin
              board[rook_dst_sq] <= board[rook_src_sq];
              board[rook_src_sq] <= '0;
            end
            castle   <= castle_nxt;
            wtp      <= !wtp;
            ep_valid <= dbl_push;
            if (dbl_push) ep <= from_f;
          end
        end
        S_STREAM: if (!idx[IDX_W]) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pos_valid <= 1'b0;
      out_pos_data  <= '0;
      out_pos_sop   <= 1'b0;
      out_pos_eop   <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      out_pos_valid <= (state == S_STREAM) && !idx[IDX_W];
      out_pos_data  <= ((state == S_STREAM) && !idx[IDX_W]) ? board[idx[IDX_W-1:0]] : '0;
      out_pos_sop   <= (state == S_STREAM) && (idx == '0);
      out_pos_eop   <= (state == S_STREAM) && (idx == LAST_IDX);
      o_err         <= (state == S_APPLY) && reject;
    end
  end

endmodule

// File: tb/tb_board_pos_streamer.sv
// Directed bench for board_pos_streamer: a hand-maintained board model feeds an
// expected-beat queue that is drained against the serial stream.
`timescale 1ns/1ps
module tb_board_pos_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_pos_valid, in_pos_sop, in_pos_eop;
  logic [3:0]  in_pos_data;
  logic        in_wtp;
  logic [3:0]  in_castle;
  logic [2:0]  in_ep;
  logic        in_ep_valid;
  logic        i_uci_valid;
  logic [19:0] i_uci_data;
  logic        i_uci_ready;
  logic        start;
  logic        out_pos_valid, out_pos_sop, out_pos_eop;
  logic [3:0]  out_pos_data;
  logic        out_wtp;
  logic [3:0]  out_castle;
  logic [2:0]  out_ep;
  logic        out_ep_valid;
  logic        o_busy, o_err;

  logic [3:0]  model [64];
  logic [3:0]  exp_q [$];
  logic        e_wtp;
  logic [3:0]  e_castle;
  logic [2:0]  e_ep;
  logic        e_epv;
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  board_pos_streamer #(.SQUARES(64), .PIECE_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_pos_valid(in_pos_valid), .in_pos_data(in_pos_data),
    .in_pos_sop(in_pos_sop), .in_pos_eop(in_pos_eop),
    .in_wtp(in_wtp), .in_castle(in_castle), .in_ep(in_ep), .in_ep_valid(in_ep_valid),
    .i_uci_valid(i_uci_valid), .i_uci_data(i_uci_data), .i_uci_ready(i_uci_ready),
    .start(start),
    .out_pos_valid(out_pos_valid), .out_pos_data(out_pos_data),
    .out_pos_sop(out_pos_sop), .out_pos_eop(out_pos_eop),
    .out_wtp(out_wtp), .out_castle(out_castle), .out_ep(out_ep), .out_ep_valid(out_ep_valid),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = 4'h0;
  endtask

  task automatic set_start_pos();
    logic [3:0] back [8];
    back = '{4'h3, 4'h5, 4'h4, 4'h2, 4'h1, 4'h4, 4'h5, 4'h3};
    clear_model();
    for (int f = 0; f < 8; f++) begin
      model[f]      = back[f] | 4'h8;
      model[8 + f]  = 4'hE;
      model[48 + f] = 4'h6;
      model[56 + f] = back[f];
    end
  endtask

  task automatic load_board(input logic w, input logic [3:0] c, input logic [2:0] e, input logic ev);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      in_pos_valid = 1'b1;
      in_pos_data  = model[i];
      in_pos_sop   = (i == 0);
      in_pos_eop   = (i == 63);
      in_wtp       = w;
      in_castle    = c;
      in_ep        = e;
      in_ep_valid  = ev;
    end
    @(posedge clk); #1;
    in_pos_valid = 1'b0;
    in_pos_sop   = 1'b0;
    in_pos_eop   = 1'b0;
    e_wtp = w; e_castle = c; e_ep = e; e_epv = ev;
  endtask

  task automatic do_move(input string tag, input logic [2:0] fr, input logic [2:0] ff,
                         input logic [2:0] tr, input logic [2:0] tf, input logic [1:0] pr,
                         input logic exp_err);
    @(posedge clk); #1;
    chk({tag, "_ready"}, i_uci_ready, 1);
    i_uci_valid = 1'b1;
    i_uci_data  = {pr, 3'd0, fr, ff, 3'd0, tr, tf};
    @(posedge clk); #1;
    i_uci_valid = 1'b0;
    chk({tag, "_busy_apply"}, o_busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_err_pulse"}, o_err, exp_err);
    @(negedge clk);
    chk({tag, "_err_clear"}, o_err, 0);
  endtask

  task automatic stream_check(input string tag, input int start_at, input int rst_at);
    int  beats;
    int  cyc;
    bit  done;
    bit  aborted;
    logic [3:0] e;
    beats = 0; cyc = 0; done = 0; aborted = 0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(model[i]);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (out_pos_valid) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_beat"}, out_pos_valid, 0);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("%s_data%0d", tag, beats), out_pos_data, e);
          chk($sformatf("%s_sop%0d", tag, beats), out_pos_sop, (beats == 0));
          chk($sformatf("%s_eop%0d", tag, beats), out_pos_eop, (beats == 63));
          chk($sformatf("%s_side%0d", tag, beats),
              {out_wtp, out_castle, out_ep, out_ep_valid}, {e_wtp, e_castle, e_ep, e_epv});
          if (beats == start_at) start = 1'b1;
          if (beats == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk({tag, "_rst_valid"}, out_pos_valid, 0);
            chk({tag, "_rst_eop"}, out_pos_eop, 0);
            chk({tag, "_rst_busy"}, o_busy, 0);
            exp_q.delete();
            @(negedge clk);
            rst_n   = 1'b1;
            aborted = 1;
            done    = 1;
          end
          beats++;
          if (!done && beats == 64) begin
            chk({tag, "_busy_eop"}, o_busy, 1);
            @(negedge clk);
            chk({tag, "_valid_end"}, out_pos_valid, 0);
            chk({tag, "_busy_end"}, o_busy, 0);
            done = 1;
          end
        end
      end else if (beats > 0) begin
        chk({tag, "_contig"}, out_pos_valid, 1);
        done = 1;
      end
    end
    if (!aborted) chk({tag, "_beats"}, beats, 64);
    if (start_at >= 0) begin
      repeat (4) begin
        @(negedge clk);
        chk({tag, "_no_restream"}, out_pos_valid, 0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_pos_valid = 0; in_pos_data = 0; in_pos_sop = 0; in_pos_eop = 0;
    in_wtp = 0; in_castle = 0; in_ep = 0; in_ep_valid = 0;
    i_uci_valid = 0; i_uci_data = 0; start = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_pos_valid, 0);
    chk("rst_sop_eop", {out_pos_sop, out_pos_eop}, 0);
    chk("rst_wtp", out_wtp, 1);
    chk("rst_castle", out_castle, 0);
    chk("rst_ep", {out_ep, out_ep_valid}, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", i_uci_ready, 1);

    // start position stream
    set_start_pos();
    load_board(1'b1, 4'hF, 3'd0, 1'b0);
    stream_check("t1", -1, -1);

    // e2e4
    do_move("t2", 3'd1, 3'd4, 3'd3, 3'd4, 2'd0, 1'b0);
    model[12] = 4'h0; model[28] = 4'hE;
    e_wtp = 1'b0; e_ep = 3'd4; e_epv = 1'b1;
    stream_check("t2", -1, -1);

    // black to move, try moving the white g1 knight
    do_move("t5", 3'd0, 3'd6, 3'd2, 3'd5, 2'd0, 1'b1);
    stream_check("t5", -1, -1);

    // white short castle, then black a8 rook move
    clear_model();
    model[4] = 4'h9; model[7] = 4'hB; model[60] = 4'h1; model[56] = 4'h3;
    load_board(1'b1, 4'hF, 3'd0, 1'b0);
    do_move("t3a", 3'd0, 3'd4, 3'd0, 3'd6, 2'd0, 1'b0);
    model[4] = 4'h0; model[6] = 4'h9; model[5] = 4'hB; model[7] = 4'h0;
    e_wtp = 1'b0; e_castle = 4'h3;
    stream_check("t3a", -1, -1);
    do_move("t3b", 3'd7, 3'd0, 3'd6, 3'd0, 2'd0, 1'b0);
    model[56] = 4'h0; model[48] = 4'h3;
    e_wtp = 1'b1; e_castle = 4'h2;
    stream_check("t3b", -1, -1);

    // b7b8 underpromotion to knight
    clear_model();
    model[49] = 4'hE; model[4] = 4'h9; model[60] = 4'h1;
    load_board(1'b1, 4'h0, 3'd0, 1'b0);
    do_move("t4a", 3'd6, 3'd1, 3'd7, 3'd1, 2'd3, 1'b0);
    model[49] = 4'h0; model[57] = 4'hD;
    e_wtp = 1'b0;
    stream_check("t4a", -1, -1);

    // black en-passant d4xe3
    clear_model();
    model[27] = 4'h6; model[28] = 4'hE;
    load_board(1'b0, 4'h0, 3'd4, 1'b1);
    do_move("t4b", 3'd3, 3'd3, 3'd2, 3'd4, 2'd0, 1'b0);
    model[27] = 4'h0; model[28] = 4'h0; model[20] = 4'h6;
    e_wtp = 1'b1; e_epv = 1'b0;
    stream_check("t4b", -1, -1);

    // start during a stream is dropped; reset mid-stream aborts
    set_start_pos();
    load_board(1'b1, 4'hF, 3'd0, 1'b0);
    stream_check("t6a", 30, -1);
    stream_check("t6b", -1, 40);
    clear_model();
    e_wtp = 1'b1; e_castle = 4'h0; e_ep = 3'd0; e_epv = 1'b0;
    stream_check("t6c", -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
